// File: rtl/regbank_seq.sv
// Round-robin sequencer for a bank of tri-state registers: grants one of two
// requesters, drives both read buses for two cycles, then loads the destination.
module regbank_seq #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req,
    input  logic [AW-1:0]   srca0,
    input  logic [AW-1:0]   srcb0,
    input  logic [AW-1:0]   dst0,
    input  logic            wr0,
    input  logic [AW-1:0]   srca1,
    input  logic [AW-1:0]   srcb1,
    input  logic [AW-1:0]   dst1,
    input  logic            wr1,
    output logic [NREG-1:0] ld,
    output logic [NREG-1:0] oea,
    output logic [NREG-1:0] oeb,
    output logic [1:0]      ack,
    output logic            busy,
    output logic            gnt_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] srca_q, srca_d;
    logic [AW-1:0] srcb_q, srcb_d;
    logic [AW-1:0] dst_q, dst_d;
    logic          wr_q, wr_d;
    logic          gnt_q, gnt_d;
    logic          winner;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            srca_q   <= '0;
            srcb_q   <= '0;
            dst_q    <= '0;
            wr_q     <= 1'b0;
            gnt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            dst_q    <= dst_d;
            wr_q     <= wr_d;
            gnt_q    <= gnt_d;
        end
    end

    // With both requesting, the pointer picks; otherwise the lone requester wins.
    always_comb begin
        winner = (req[0] && req[1]) ? rr_ptr_q : req[1];
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        dst_d    = dst_q;
        wr_d     = wr_q;
        gnt_d    = gnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d    = winner;
                    rr_ptr_d = ~winner;
                    srca_d   = winner ? srca1 : srca0;
                    srcb_d   = winner ? srcb1 : srcb0;
                    dst_d    = winner ? dst1  : dst0;
                    wr_d     = winner ? wr1   : wr0;
                    state_d  = READ;
                end
            end
            READ:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs come only from registered state, so reset clears them at once.
    always_comb begin
        ld     = '0;
        oea    = '0;
        oeb    = '0;
        ack    = 2'b00;
        busy   = 1'b0;
        gnt_id = gnt_q;
        if (state_q == READ || state_q == WRITE) begin
            busy = 1'b1;
            oea  = ONE << srca_q;
            oeb  = ONE << srcb_q;
        end
        if (state_q == WRITE) begin
            ack = gnt_q ? 2'b10 : 2'b01;
            if (wr_q) begin
                ld = ONE << dst_q;
            end
        end
    end

endmodule

// File: tb/tb_regbank_seq.sv
// Directed self-checking bench for regbank_seq with hand-computed expectations.
module tb_regbank_seq;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [2:0] srca0, srcb0, dst0, srca1, srcb1, dst1;
    logic       wr0, wr1;
    logic [7:0] ld, oea, oeb;
    logic [1:0] ack;
    logic       busy, gnt_id;

    int total_checks;
    int bad_checks;

    regbank_seq #(.NREG(8), .AW(3)) dut (
        .clk(clk), .reset(reset), .req(req),
        .srca0(srca0), .srcb0(srcb0), .dst0(dst0), .wr0(wr0),
        .srca1(srca1), .srcb1(srcb1), .dst1(dst1), .wr1(wr1),
        .ld(ld), .oea(oea), .oeb(oeb), .ack(ack), .busy(busy), .gnt_id(gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ld"}, 32'(ld), 32'h0);
        checkOutput({tag, "_oea"}, 32'(oea), 32'h0);
        checkOutput({tag, "_oeb"}, 32'(oeb), 32'h0);
        checkOutput({tag, "_ack"}, 32'(ack), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        reset = 1'b0;
        req   = 2'b11;
        srca0 = 3'd3; srcb0 = 3'd5; dst0 = 3'd6; wr0 = 1'b1;
        srca1 = 3'd2; srcb1 = 3'd2; dst1 = 3'd0; wr1 = 1'b0;

        // Reset held with both requesting: everything quiet.
        repeat (3) applyStimulus();
        checkIdle("rst");
        checkOutput("rst_gnt", 32'(gnt_id), 32'h0);
        reset = 1'b1;

        // First grant after reset goes to requester 0; req dropped after grant.
        applyStimulus();
        checkOutput("first_gnt", 32'(gnt_id), 32'h0);
        checkOutput("first_busy", 32'(busy), 32'h1);
        checkOutput("first_oea", 32'(oea), 32'h08);
        checkOutput("first_oeb", 32'(oeb), 32'h20);
        checkOutput("first_ld", 32'(ld), 32'h0);
        req = 2'b00;
        applyStimulus();
        checkOutput("first_wr_ld", 32'(ld), 32'h40);
        checkOutput("first_wr_ack", 32'(ack), 32'h1);
        checkOutput("first_wr_oea", 32'(oea), 32'h08);
        checkOutput("first_wr_oeb", 32'(oeb), 32'h20);
        applyStimulus();
        checkIdle("first_after");

        // Single write-back from requester 0 alone.
        req = 2'b01;
        applyStimulus();
        checkOutput("wb_oea", 32'(oea), 32'h08);
        checkOutput("wb_oeb", 32'(oeb), 32'h20);
        checkOutput("wb_ld", 32'(ld), 32'h0);
        checkOutput("wb_gnt", 32'(gnt_id), 32'h0);
        applyStimulus();
        checkOutput("wb_wr_ld", 32'(ld), 32'h40);
        checkOutput("wb_wr_ack", 32'(ack), 32'h1);
        req = 2'b00;
        applyStimulus();
        checkIdle("wb_after");

        // Read-only op, same register on both buses.
        req = 2'b10;
        applyStimulus();
        checkOutput("ro_oea", 32'(oea), 32'h04);
        checkOutput("ro_oeb", 32'(oeb), 32'h04);
        checkOutput("ro_ld", 32'(ld), 32'h0);
        checkOutput("ro_gnt", 32'(gnt_id), 32'h1);
        applyStimulus();
        checkOutput("ro_wr_oea", 32'(oea), 32'h04);
        checkOutput("ro_wr_oeb", 32'(oeb), 32'h04);
        checkOutput("ro_wr_ld", 32'(ld), 32'h0);
        checkOutput("ro_wr_ack", 32'(ack), 32'h2);
        req = 2'b00;
        applyStimulus();
        checkIdle("ro_after");

        // Both held: grants alternate 0,1,0,1 with ack every third cycle.
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic exp_gnt;
            exp_gnt = (i % 2 == 1);
            applyStimulus();
            checkOutput("rr_gnt", 32'(gnt_id), 32'(exp_gnt));
            checkOutput("rr_read_ack", 32'(ack), 32'h0);
            applyStimulus();
            checkOutput("rr_ack", 32'(ack), exp_gnt ? 32'h2 : 32'h1);
            checkOutput("rr_ld", 32'(ld), exp_gnt ? 32'h0 : 32'h40);
            applyStimulus();
            checkOutput("rr_idle_ack", 32'(ack), 32'h0);
            checkOutput("rr_idle_busy", 32'(busy), 32'h0);
            if (i == 3) req = 2'b00;
        end

        // Destination changed during READ: latched value still used.
        req = 2'b01; dst0 = 3'd1; wr0 = 1'b1;
        applyStimulus();
        dst0 = 3'd7;
        req  = 2'b00;
        applyStimulus();
        checkOutput("latch_ld", 32'(ld), 32'h02);
        checkOutput("latch_ack", 32'(ack), 32'h1);
        applyStimulus();
        checkIdle("latch_after");

        // Reset during WRITE: ld drops immediately, no ack, pointer back to 0.
        req = 2'b01; dst0 = 3'd6;
        applyStimulus();
        req = 2'b00;
        applyStimulus();
        checkOutput("mid_pre_ld", 32'(ld), 32'h40);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_ld", 32'(ld), 32'h0);
        checkOutput("mid_ack", 32'(ack), 32'h0);
        checkOutput("mid_busy", 32'(busy), 32'h0);
        applyStimulus();
        checkIdle("mid_held");
        #3 reset = 1'b1;
        req = 2'b11;
        applyStimulus();
        checkOutput("mid_regrant", 32'(gnt_id), 32'h0);
        checkOutput("mid_regrant_busy", 32'(busy), 32'h1);
        req = 2'b00;
        applyStimulus();
        checkOutput("mid_regrant_ack", 32'(ack), 32'h1);
        applyStimulus();
        checkIdle("end");

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/regbank_seq.md
Name: regbank_seq

Overview:
- Sequencer and arbiter for a bank of NREG 16-bit tri-state-output registers. Each register has `ld`, `oea` and `oeb` controls and drives the shared A and B buses.
- Two requesters each issue an operation: a source register onto bus A, a source register onto bus B, and an optional write-back of `din` into a destination register.
- The block arbitrates round-robin, sequences READ then WRITE, and drives the one-hot enables.
- It guarantees no bus contention.

Parameters:
- NREG, 8, number of registers in the bank (one-hot enable width).
- AW, 3, register select width; NREG must equal 2**AW.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  2  `req[i]` high = requester i has an operation pending; held until `ack[i]`.
- srca0, srcb0, dst0  in  AW each  requester 0: bus A source, bus B source, write-back destination.
- wr0  in  1  requester 0 write-back enable.
- srca1, srcb1, dst1  in  AW each  requester 1: same fields as requester 0.
- wr1  in  1  requester 1 write-back enable.
- ld  out  NREG  one-hot load enables to the bank.
- oea  out  NREG  one-hot bus A output enables.
- oeb  out  NREG  one-hot bus B output enables.
- ack  out  2  one-cycle completion pulse per requester.
- busy  out  1  high while in READ or WRITE.
- gnt_id  out  1  index of the requester currently being served; valid while `busy`.

Behaviour:
- Reset (`reset`=0, asynchronous): state=IDLE, rr_ptr=0, latched fields=0.
  - `ld`, `oea`, `oeb`, `ack`, `busy`, `gnt_id` all 0 immediately.
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - All enables 0.
  - If any `req` bit is high, grant per the arbitration rules below.
  - On grant: latch that requester's srca/srcb/dst/wr and `gnt_id`, then go to READ.
  - If no `req`, stay in IDLE.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester equal to rr_ptr wins.
  - After any grant, rr_ptr = ~winner.
- READ (1 cycle):
  - `oea[srca]`=1, `oeb[srcb]`=1, all other bits 0, `ld`=0, `busy`=1.
  - Provides one cycle for the external datapath to settle `din`.
  - Always go to WRITE.
- WRITE (1 cycle):
  - `oea` and `oeb` held as in READ.
  - `ld[dst]`=1 if the latched wr=1, else `ld`=0.
  - `ack[gnt_id]`=1, `busy`=1.
  - The destination register captures `din` on the rising edge that ends WRITE.
  - Always go to IDLE.
- Latency: grant edge to `ack` = 2 cycles. Throughput: one operation per 3 cycles.
- Outputs are decoded from registered state and latched fields only, never from live `req`/field inputs. Field changes after grant have no effect.
- Invariants (every cycle):
  - At most one bit of `oea` high, at most one of `oeb`, at most one of `ld`.
  - At most one `ack` bit high.
  - `ack` is never high outside WRITE.
- Boundaries:
  - srca==srcb: the same register drives both buses (legal, separate buses).
  - dst==srca or dst==srcb: legal; the new value becomes visible in the next operation.
  - wr=0: read-only operation; `ack` still pulses.
  - `req` dropped after grant: the operation completes and `ack` still pulses.
  - Requester holds `req` through `ack`: must deassert on the edge after `ack`. If still high in IDLE, it is treated as a new request.
  - Reset asserted during READ or WRITE: enables drop at once and no `ld` reaches the bank. After reset release, FSM starts in IDLE with rr_ptr=0.
  - Register select indices are always < NREG by construction; no out-of-range handling.

Test Plan:
- Reset check: hold `reset`=0 with `req`=2'b11, then release → while held, all outputs 0; first grant after release goes to requester 0 (`gnt_id`=0).
- Single write-back: `req`=01 with srca0=3, srcb0=5, dst0=6, wr0=1:
  - cycle READ: `oea`=8'h08, `oeb`=8'h20, `ld`=0.
  - cycle WRITE: `ld`=8'h40, `ack`=01.
  - next cycle: all enables 0.
- Round-robin fairness: both `req` held continuously → grants alternate 0,1,0,1. Each `ack` is spaced 3 cycles apart, and no requester is served twice in a row.
- Read-only op with identical sources: `req`=10 with srca1=srcb1=2, wr1=0 → `oea`=`oeb`=8'h04 for 2 cycles, `ld` stays 0, `ack`=10.
- Mid-op reset: assert `reset`=0 during WRITE with wr=1 → `ld` falls to 0 asynchronously and no `ack` pulse occurs. After release: IDLE, rr_ptr=0.
- Field change after grant: change dst0 from 1 to 7 during READ → `ld`=8'h02 (latched value) in WRITE.
